apb_master: RTL

APB requester that turns single-beat commands from a local valid/ready interface into APB3 transfers (SETUP then ACCESS), and returns read data and error status on a response channel. It sits between an on-chip controller or test sequencer and the APB peripheral bus. It adds a bounded wait on `pready`, so a missing or hung responder produces an error response instead of stalling the bus.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_wait_timer.sv | 41 ++++
 rtl/apb_master.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester.
// No logic; state encoding, default bus widths and register offsets.
// Imported by the RTL and by the bench.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_m_state_t;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Register offsets of the peripherals exercised on this bus
  localparam logic [31:0] REG_OFF_0 = 32'h0;
  localparam logic [31:0] REG_OFF_4 = 32'h4;
  localparam logic [31:0] REG_OFF_8 = 32'h8;
  localparam logic [31:0] REG_OFF_C = 32'hC;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with pready low; flags the LIMIT-th such cycle.
// Latency: expire is a decode of the registered count (same cycle).
// Backpressure: none; clear wins over enable, count saturates at LIMIT.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear restarts, enable advances without wrapping past LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle whose count is LIMIT-1 is the LIMIT-th consecutive low cycle;
  // kept independent of enable so the caller's decode has no loop through it.
  assign expire = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one command -> SETUP + ACCESS, result on a response pulse.
// Latency: accept at edge k, rsp_valid in cycle k+3+wait states (k+2+TIMEOUT on abort).
// Backpressure: cmd_ready only in IDLE; response channel has none.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_m_state_t      state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic tmr_clear, tmr_en, tmr_expire;

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timer
      apb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .pclk   (pclk),
        .preset (preset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expire (tmr_expire)
      );
    end else begin : g_no_timer
      assign tmr_expire = 1'b0;
    end
  endgenerate

  // Only unregistered output: ready is a decode of IDLE, masked during reset
  assign cmd_ready = (state_q == ST_IDLE) && !preset;

  // Transfer sequencing and response generation
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    tmr_clear     = 1'b0;
    tmr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // pready is deliberately ignored here: a stale high must not complete
        penable_d = 1'b1;
        tmr_clear = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          // Normal completion beats a timeout landing on the same cycle
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expire) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = ST_IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command silently
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
